// File: rtl/uart_cmd_wrapper_pkg.sv
// uart_cmd_wrapper_pkg: shared assembler state, default bit period and ack byte
package uart_cmd_wrapper_pkg;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
  localparam int BAUD_DIV_DEF = 2604;
  localparam logic [7:0] ACK = 8'hA5;
endpackage

// File: rtl/uart_trx.sv
// uart_trx: 8N1 receiver and transmitter running independently off one bit period
module uart_trx
  import uart_cmd_wrapper_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t rs;
  logic rx_s1, rx_s2, rx_prev, busy;
  logic [CW-1:0] rcnt, tcnt;
  logic [2:0] rbit;
  logic [3:0] tbit;
  logic [7:0] rsh;
  logic [9:0] tsh;
  // every receive sample after the mid-start one lands a full bit period later
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
      rs <= R_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rsh <= '0;
      rx_rdy <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_rdy <= 1'b0;
      rcnt <= (rs == R_IDLE) ? '0 : rcnt + 1'b1;
      case (rs)
        R_IDLE: if (rx_prev && !rx_s2) rs <= R_START;
        R_START: if (rcnt == HALF) begin
          rcnt <= '0;
          rs <= rx_s2 ? R_IDLE : R_DATA;
        end
        R_DATA: if (rcnt == FULL) begin
          rcnt <= '0;
          rsh <= {rx_s2, rsh[7:1]};
          rbit <= rbit + 1'b1;
          if (rbit == 3'd7) rs <= R_STOP;
        end
        R_STOP: if (rcnt == FULL) begin
          rs <= R_IDLE;
          rx_rdy <= rx_s2;
          if (rx_s2) rx_data <= rsh;
        end
        default: rs <= R_IDLE;
      endcase
    end
  // tsh holds {stop, data, start}; tx is the registered copy of the current bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx <= 1'b1;
      busy <= 1'b0;
      tcnt <= '0;
      tbit <= '0;
      tsh <= '1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!busy) begin
        if (trmt) begin
          busy <= 1'b1;
          tsh <= {1'b1, tx_data, 1'b0};
          tcnt <= '0;
          tbit <= '0;
          tx <= 1'b0;
        end
      end else if (tcnt != FULL) tcnt <= tcnt + 1'b1;
      else begin
        tcnt <= '0;
        tsh <= tsh >> 1;
        tbit <= tbit + 1'b1;
        tx <= (tbit == 4'd9) ? 1'b1 : tsh[1];
        if (tbit == 4'd9) begin
          busy <= 1'b0;
          tx_done <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: pairs received bytes into 16-bit commands and sends response bytes
module uart_cmd_wrapper
  import uart_cmd_wrapper_pkg::*;
#(
  parameter int BAUD_DIV    = BAUD_DIV_DEF,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [15:0] cmd,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  asm_state_t st;
  logic [7:0] hi, rx_data;
  logic [TW-1:0] tmo;
  logic rx_rdy;
  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk(clk), .rst(rst), .rx(RX), .tx(TX), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .trmt(trmt), .tx_data(resp), .tx_done(tx_done)
  );
  // a completed low byte sets cmd_rdy ahead of any clear in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= WAIT_HI;
      hi <= '0;
      tmo <= '0;
      cmd <= '0;
      cmd_rdy <= 1'b0;
    end else if (rx_rdy) begin
      st <= (st == WAIT_HI) ? WAIT_LO : WAIT_HI;
      tmo <= '0;
      if (st == WAIT_HI) begin
        hi <= rx_data;
        cmd_rdy <= 1'b0;
      end else begin
        cmd <= {hi, rx_data};
        cmd_rdy <= 1'b1;
      end
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (st == WAIT_LO) begin
        tmo <= tmo + 1'b1;
        if (tmo == TLAST) begin
          st <= WAIT_HI;
          tmo <= '0;
        end
      end
    end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: serial driver/decoder with a byte-pairing model of cmd/cmd_rdy
module tb_uart_cmd_wrapper;
  localparam int B = 16;
  localparam int TMO = 1000;
  logic clk = 0, rst = 1, rx = 1, clr = 0, trmt = 0;
  logic [7:0] resp = 0;
  logic tx, cmd_rdy, tx_done;
  logic [15:0] cmd;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  logic chk_en = 0;
  logic [15:0] exp_cmd = 0;
  logic exp_rdy = 0, pending = 0;
  logic [7:0] hi_b = 0;
  int hi_cyc = 0;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .RX(rx), .TX(tx), .clr_cmd_rdy(clr), .cmd_rdy(cmd_rdy),
    .cmd(cmd), .trmt(trmt), .resp(resp), .tx_done(tx_done)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  // model: bytes pair up unless the gap after the high byte exceeds the timeout
  task automatic model_byte(input logic [7:0] b);
    if (pending && (cyc - hi_cyc) <= TMO) begin
      exp_cmd = {hi_b, b};
      exp_rdy = 1;
      pending = 0;
    end else begin
      hi_b = b;
      hi_cyc = cyc;
      pending = 1;
      exp_rdy = 0;
    end
  endtask

  task automatic model_reset();
    exp_cmd = 0;
    exp_rdy = 0;
    pending = 0;
  endtask

  // called at a negedge; the stop bit is a blind window since the DUT reacts mid-stop
  task automatic send(input logic [7:0] b, input logic good, input logic clr_at_set);
    rx = 0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    chk_en = 0;
    rx = good;
    if (clr_at_set) clr = 1;
    for (int i = 0; i < B; i++) begin
      @(negedge clk);
      if (clr && cmd_rdy) clr = 0;
    end
    clr = 0;
    rx = 1;
    if (good) model_byte(b);
    chk_en = 1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (chk_en) begin
      checks++;
      if (cmd !== exp_cmd || cmd_rdy !== exp_rdy) begin
        errors++;
        if (errors < 20)
          $display("FAIL model cyc %0d got cmd=%h rdy=%b want cmd=%h rdy=%b",
                   cyc, cmd, cmd_rdy, exp_cmd, exp_rdy);
      end
    end
  end

  initial begin
    logic [7:0] d, part;
    int acc, w;
    logic ok;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(tx), 16'h1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", 16'(cmd_rdy), 16'h0);
    chk("rst_tx_done", 16'(tx_done), 16'h0);
    rst = 0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    send(8'h30, 1, 0);
    send(8'h01, 1, 0);
    chk("cmd_3001", cmd, 16'h3001);
    chk("rdy_3001", 16'(cmd_rdy), 16'h1);
    clr = 1;
    exp_rdy = 0;
    @(negedge clk);
    clr = 0;
    chk("clr_rdy", 16'(cmd_rdy), 16'h0);
    chk("clr_cmd_hold", cmd, 16'h3001);

    resp = 8'hA5;
    trmt = 1;
    acc = cyc + 1;
    @(negedge clk);
    trmt = 0;
    fork
      begin
        w = 0;
        while (tx !== 1'b0 && w < 20) begin
          @(negedge clk);
          w++;
        end
        repeat (B / 2) @(negedge clk);
        chk("tx_start_bit", 16'(tx), 16'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          d[i] = tx;
        end
        repeat (B) @(negedge clk);
        chk("tx_stop_bit", 16'(tx), 16'h1);
        chk("tx_byte", 16'(d), 16'h00A5);
      end
      begin
        repeat (99) @(negedge clk);
        resp = 8'h3C;
        trmt = 1;
        @(negedge clk);
        trmt = 0;
      end
      begin
        send(8'h77, 1, 0);
        send(8'h88, 1, 0);
      end
    join
    repeat (200) @(negedge clk);
    chk("tx_done_count", 16'(done_cnt), 16'h1);
    ok = (done_cyc - acc >= 10 * B - 1) && (done_cyc - acc <= 10 * B + 1);
    chk("tx_done_time", ok ? 16'(10 * B) : 16'(done_cyc - acc), 16'(10 * B));
    chk("tx_idle", 16'(tx), 16'h1);
    chk("cmd_duplex", cmd, 16'h7788);

    send(8'h11, 1, 0);
    part = 8'h22;
    rx = 0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      repeat (B) @(negedge clk);
    end
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("midrst_tx", 16'(tx), 16'h1);
    chk("midrst_cmd", cmd, 16'h0000);
    chk("midrst_rdy", 16'(cmd_rdy), 16'h0);
    chk("midrst_tx_done", 16'(tx_done), 16'h0);
    rx = 1;
    rst = 0;
    repeat (2 * B) @(negedge clk);
    send(8'hAB, 1, 0);
    send(8'hCD, 1, 0);
    chk("cmd_abcd", cmd, 16'hABCD);
    chk("rdy_abcd", 16'(cmd_rdy), 16'h1);

    send(8'h12, 1, 0);
    repeat (2000) @(negedge clk);
    send(8'h34, 1, 0);
    send(8'h56, 1, 0);
    chk("cmd_timeout", cmd, 16'h3456);

    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    repeat (2 * B) @(negedge clk);
    send(8'hEE, 0, 0);
    repeat (B) @(negedge clk);
    send(8'h00, 1, 0);
    send(8'h00, 1, 0);
    chk("cmd_framing", cmd, 16'h0000);
    chk("rdy_framing", 16'(cmd_rdy), 16'h1);

    send(8'h9A, 1, 0);
    send(8'hBC, 1, 1);
    repeat (3) @(negedge clk);
    chk("set_beats_clr", 16'(cmd_rdy), 16'h1);
    chk("cmd_9abc", cmd, 16'h9ABC);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
